// File: rtl/clint.sv
// clint: machine timer (mtime/mtimecmp) and software interrupt (msip) block.
// Ports: clk, rst (sync, active-low); mem_valid/addr/wdata/wstrb request,
//   mem_rdata/mem_ready response one cycle later; msip, mtip, mtime to csr.
// Optional prescaler: define CLINT_PRESCALER_EN to tick mtime every
//   CLINT_DIV clocks; otherwise mtime ticks every clock.
module clint #(
    parameter int unsigned CLINT_DIV = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        msip,
    output logic        mtip,
    output logic [63:0] mtime
);

    localparam logic [15:0] OFF_MSIP   = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI = 16'h4004;
    localparam logic [15:0] OFF_TIM_LO = 16'hBFF8;
    localparam logic [15:0] OFF_TIM_HI = 16'hBFFC;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic        msip_q, msip_d;
    logic        mtip_q, mtip_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] off;
    logic        wr;
    logic        tick;
    logic        unused_addr;

    assign off         = mem_addr[15:0];
    assign wr          = mem_valid && (mem_wstrb != 4'b0000);
    assign unused_addr = ^mem_addr[31:16];

`ifdef CLINT_PRESCALER_EN
    logic [15:0] cnt_q, cnt_d;

    // Counter free-runs; mtime writes deliberately leave it alone.
    assign tick = (cnt_q == 16'(CLINT_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (tick) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [15:0] unused_div;

    assign unused_div = 16'(CLINT_DIV);
    assign tick       = 1'b1;
`endif

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  st
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) begin
                r[b*8 +: 8] = wd[b*8 +: 8];
            end
        end
        return r;
    endfunction

    always_comb begin
        mtime_d = mtime_q;
        cmp_d   = cmp_q;
        msip_d  = msip_q;
        ready_d = mem_valid;
        rdata_d = 32'd0;
        // Compare uses current registers, so mtip lags by one cycle.
        mtip_d  = (mtime_q >= cmp_q);
        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        // Read data is the pre-write value; an mtime write replaces the
        // tick for that cycle and never carries into the other half.
        if (mem_valid) begin
            case (off)
                OFF_MSIP: begin
                    rdata_d = {31'd0, msip_q};
                    if (wr && mem_wstrb[0]) begin
                        msip_d = mem_wdata[0];
                    end
                end
                OFF_CMP_LO: begin
                    rdata_d = cmp_q[31:0];
                    if (wr) begin
                        cmp_d[31:0] = merge(cmp_q[31:0], mem_wdata, mem_wstrb);
                    end
                end
                OFF_CMP_HI: begin
                    rdata_d = cmp_q[63:32];
                    if (wr) begin
                        cmp_d[63:32] = merge(cmp_q[63:32], mem_wdata, mem_wstrb);
                    end
                end
                OFF_TIM_LO: begin
                    rdata_d = mtime_q[31:0];
                    if (wr) begin
                        mtime_d = {mtime_q[63:32],
                                   merge(mtime_q[31:0], mem_wdata, mem_wstrb)};
                    end
                end
                OFF_TIM_HI: begin
                    rdata_d = mtime_q[63:32];
                    if (wr) begin
                        mtime_d = {merge(mtime_q[63:32], mem_wdata, mem_wstrb),
                                   mtime_q[31:0]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_q <= 64'd0;
            cmp_q   <= '1;
            msip_q  <= 1'b0;
            mtip_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            msip_q  <= msip_d;
            mtip_q  <= mtip_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    // A response pending when reset falls is suppressed immediately.
    assign mem_ready = ready_q & rst;
    assign mem_rdata = rst ? rdata_q : 32'd0;
    assign msip      = msip_q;
    assign mtip      = mtip_q;
    assign mtime     = mtime_q;

endmodule

// File: tb/tb_clint.sv
// tb_clint: table vectors, directed corner sequences and random traffic
// checked against a cycle-level behavioural model of the clint.
module tb_clint;

`ifdef CLINT_PRESCALER_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        msip;
    logic        mtip;
    logic [63:0] mtime;

    int checks = 0;
    int errors = 0;

    clint #(.CLINT_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .msip      (msip),
        .mtip      (mtip),
        .mtime     (mtime)
    );

    always #5 clk = ~clk;

    // behavioural model state
    longint unsigned m_time, m_cmp, m_cyc;
    bit              m_msip, m_mtip, m_rdy;
    logic [31:0]     m_rdata;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mmerge(input logic [31:0] old,
                                           input logic [31:0] wd,
                                           input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mread(input logic [15:0] off);
        case (off)
            16'h0000: return {31'd0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_time[31:0];
            16'hBFFC: return m_time[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    task automatic step(input bit v, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input bit r);
        longint unsigned nt, nc, ncyc;
        bit nms, nmt, nrdy;
        logic [31:0] nrd;
        logic [15:0] off;
        mem_valid = v;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        rst       = r;
        off       = a[15:0];
        if (!r) begin
            nt = 0; nc = '1; nms = 0; nmt = 0; nrdy = 0; nrd = 0; ncyc = 0;
        end else begin
            nt   = ((m_cyc % DIV) == DIV - 1) ? m_time + 1 : m_time;
            nc   = m_cmp;
            nms  = m_msip;
            nmt  = (m_time >= m_cmp);
            nrdy = v;
            nrd  = v ? mread(off) : 32'd0;
            ncyc = m_cyc + 1;
            if (v && ws != 4'b0000) begin
                case (off)
                    16'h0000: if (ws[0]) nms = wd[0];
                    16'h4000: nc[31:0]  = mmerge(m_cmp[31:0], wd, ws);
                    16'h4004: nc[63:32] = mmerge(m_cmp[63:32], wd, ws);
                    16'hBFF8: nt = {m_time[63:32], mmerge(m_time[31:0], wd, ws)};
                    16'hBFFC: nt = {mmerge(m_time[63:32], wd, ws), m_time[31:0]};
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        m_time = nt; m_cmp = nc; m_msip = nms; m_mtip = nmt;
        m_rdy = nrdy; m_rdata = nrd; m_cyc = ncyc;
        chk("ready", {63'd0, mem_ready}, {63'd0, m_rdy && rst});
        chk("rdata", {32'd0, mem_rdata}, {32'd0, (m_rdy && rst) ? m_rdata : 32'd0});
        chk("msip", {63'd0, msip}, {63'd0, m_msip});
        chk("mtip", {63'd0, mtip}, {63'd0, m_mtip});
        chk("mtime", mtime, m_time);
        mem_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        step(1, a, d, s, 1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_msip;
    } vec_t;

    vec_t tbl[16];

    initial begin
        bit hit;
        logic [15:0] offs[7];
        int k;

        tbl[0]  = '{32'h0000_0000, 32'h0000_0001, 4'b0001, 32'h0000_0000, 1'b1};
        tbl[1]  = '{32'h0000_0000, 32'h0,         4'b0000, 32'h0000_0001, 1'b1};
        tbl[2]  = '{32'h0000_0000, 32'h0,         4'b0001, 32'h0000_0001, 1'b0};
        tbl[3]  = '{32'h0000_0000, 32'h0,         4'b0000, 32'h0000_0000, 1'b0};
        tbl[4]  = '{32'h0000_4000, 32'h0,         4'b0000, 32'hFFFF_FFFF, 1'b0};
        tbl[5]  = '{32'h0000_1234, 32'h0,         4'b0000, 32'h0000_0000, 1'b0};
        tbl[6]  = '{32'h0000_4000, 32'h0000_AB00, 4'b0010, 32'hFFFF_FFFF, 1'b0};
        tbl[7]  = '{32'h0000_4000, 32'h0,         4'b0000, 32'hFFFF_ABFF, 1'b0};
        tbl[8]  = '{32'h0000_4004, 32'h0,         4'b0000, 32'hFFFF_FFFF, 1'b0};
        tbl[9]  = '{32'h0000_0000, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1};
        tbl[10] = '{32'h0000_0000, 32'h0,         4'b0000, 32'h0000_0001, 1'b1};
        tbl[11] = '{32'h0000_0000, 32'h0,         4'b0001, 32'h0000_0001, 1'b0};
        tbl[12] = '{32'h0001_0000, 32'h0,         4'b0000, 32'h0000_0000, 1'b0};
        tbl[13] = '{32'h0000_4000, 32'hFFFF_FFFF, 4'b1111, 32'hFFFF_ABFF, 1'b0};
        tbl[14] = '{32'h0000_1234, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0};
        tbl[15] = '{32'h0000_4004, 32'h0,         4'b0000, 32'hFFFF_FFFF, 1'b0};

        m_time = 0; m_cmp = '1; m_cyc = 0;
        m_msip = 0; m_mtip = 0; m_rdy = 0; m_rdata = 0;

        // reset, then free-running timer with no traffic
        step(0, 0, 0, 0, 0);
        step(1, 32'h0, 32'h1, 4'b0001, 0);
        chk("rst_mtime0", mtime, 64'd0);
        chk("rst_msip0", {63'd0, msip}, 64'd0);
        idle(100);
        chk("free_run_mtime", mtime, 64'(100 / DIV));
        chk("free_run_mtip", {63'd0, mtip}, 64'd0);

        // back-to-back table vectors
        for (int i = 0; i < 16; i++) begin
            step(1, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, 1);
            chk("vec_ready", {63'd0, mem_ready}, 64'd1);
            chk("vec_rdata", {32'd0, mem_rdata}, {32'd0, tbl[i].exp_rdata});
            chk("vec_msip", {63'd0, msip}, {63'd0, tbl[i].exp_msip});
        end
        idle(1);
        chk("idle_ready", {63'd0, mem_ready}, 64'd0);

        // mtip rises one cycle after mtime reaches mtimecmp
        step(0, 0, 0, 0, 0);
        wr(32'h4004, 32'h0, 4'b1111);
        wr(32'h4000, 32'd50, 4'b1111);
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            idle(1);
            if (m_time == 50) hit = 1;
        end
        chk("cmp_reached", {63'd0, hit}, 64'd1);
        chk("mtip_before", {63'd0, mtip}, 64'd0);
        idle(1);
        chk("mtip_after", {63'd0, mtip}, 64'd1);
        wr(32'h4000, 32'hFFFF_FFFF, 4'b1111);
        wr(32'h4004, 32'hFFFF_FFFF, 4'b1111);
        idle(1);
        chk("mtip_fall", {63'd0, mtip}, 64'd0);

        // mtime wrap with mtimecmp = 0
        wr(32'h4000, 32'h0, 4'b1111);
        wr(32'h4004, 32'h0, 4'b1111);
        wr(32'hBFF8, 32'hFFFF_FFFE, 4'b1111);
        wr(32'hBFFC, 32'hFFFF_FFFF, 4'b1111);
        chk("wr_hi_no_tick", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
        idle(2 * DIV);
        chk("wrap_mtime", mtime, 64'd0);
        idle(1);
        chk("wrap_mtip", {63'd0, mtip}, 64'd1);

        // response accepted just before reset is dropped
        wr(32'h4000, 32'h0, 4'b0000);
        chk("pre_rst_ready", {63'd0, mem_ready}, 64'd1);
        rst = 1'b0;
        #1;
        chk("drop_ready", {63'd0, mem_ready}, 64'd0);
        chk("drop_rdata", {32'd0, mem_rdata}, 64'd0);
        step(1, 32'h0, 32'h1, 4'b0001, 0);
        step(1, 32'hBFF8, 32'h55, 4'b1111, 0);
        chk("rst_ignore_msip", {63'd0, msip}, 64'd0);
        chk("rst_mtime", mtime, 64'd0);

`ifdef CLINT_PRESCALER_EN
        // mtime write on a tick cycle: write wins, cadence kept
        idle(1);
        for (int i = 0; i < DIV && (m_cyc % DIV) != DIV - 1; i++) idle(1);
        wr(32'hBFF8, 32'h10, 4'b1111);
        chk("tick_wr", mtime, 64'h10);
        idle(DIV - 1);
        chk("tick_hold", mtime, 64'h10);
        idle(1);
        chk("tick_next", mtime, 64'h11);
`endif

        // random traffic against the model
        offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC,
                 16'h0008, 16'h8000};
        idle(1);
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 6);
            step($urandom_range(0, 1) == 1,
                 {16'($urandom), offs[k]},
                 ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                             : {28'd0, 4'($urandom)},
                 ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000,
                 $urandom_range(0, 63) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
